// File: rtl/gpio_32_top.sv
// 32-bit GPIO bank with an APB3 slave register interface.
// Per-pin direction/output registers, a 2-flop synchronized and debounced
// input path, and per-pin maskable edge/level interrupts merged into gpio_irq.
module gpio_32_top #(
    parameter int unsigned DEB_W = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [7:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic [31:0] gpio_in_raw,
    output logic [31:0] gpio_out,
    output logic [31:0] gpio_oe,
    output logic        gpio_irq
);

    // Register offsets
    localparam logic [7:0] ADDR_DIR      = 8'h00;
    localparam logic [7:0] ADDR_OUT      = 8'h04;
    localparam logic [7:0] ADDR_IN       = 8'h08;
    localparam logic [7:0] ADDR_MASK     = 8'h0C;
    localparam logic [7:0] ADDR_STATUS   = 8'h10;
    localparam logic [7:0] ADDR_TYPE     = 8'h14;
    localparam logic [7:0] ADDR_POLARITY = 8'h18;
    localparam logic [7:0] ADDR_DEBOUNCE = 8'h1C;

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic [31:0]      dir_q;
    logic [31:0]      out_q;
    logic [31:0]      mask_q;
    logic [31:0]      status_q;
    logic [31:0]      status_d;
    logic [31:0]      type_q;
    logic [31:0]      pol_q;
    logic [DEB_W-1:0] deb_cfg_q;

    // Input path state
    logic [31:0] sync1_q;
    logic [31:0] sync2_q;
    logic [31:0] stable;
    logic [31:0] prev_q;

    // Bus decode
    logic        wr_en;
    logic        rd_en;
    logic        wr_dir;
    logic        wr_out;
    logic        wr_mask;
    logic        wr_status;
    logic        wr_type;
    logic        wr_pol;
    logic        wr_deb;

    // Interrupt event terms
    logic [31:0] edge_ev;
    logic [31:0] level_ev;
    logic [31:0] int_ev;
    logic [31:0] w1c_bits;
    logic [31:0] deb_cfg_rd;

    assign wr_en   = PSEL & PENABLE & PWRITE;
    assign rd_en   = PSEL & ~PWRITE;
    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;

    // Decode the write target; IN and unmapped offsets select nothing
    always_comb begin
        wr_dir    = 1'b0;
        wr_out    = 1'b0;
        wr_mask   = 1'b0;
        wr_status = 1'b0;
        wr_type   = 1'b0;
        wr_pol    = 1'b0;
        wr_deb    = 1'b0;
        if (wr_en) begin
            case (PADDR)
                ADDR_DIR:      wr_dir    = 1'b1;
                ADDR_OUT:      wr_out    = 1'b1;
                ADDR_MASK:     wr_mask   = 1'b1;
                ADDR_STATUS:   wr_status = 1'b1;
                ADDR_TYPE:     wr_type   = 1'b1;
                ADDR_POLARITY: wr_pol    = 1'b1;
                ADDR_DEBOUNCE: wr_deb    = 1'b1;
                default:       ;
            endcase
        end
    end

    // Plain RW configuration registers
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            dir_q     <= '0;
            out_q     <= '0;
            mask_q    <= '0;
            type_q    <= '0;
            pol_q     <= '0;
            deb_cfg_q <= '0;
        end else begin
            if (wr_dir)  dir_q     <= PWDATA;
            if (wr_out)  out_q     <= PWDATA;
            if (wr_mask) mask_q    <= PWDATA;
            if (wr_type) type_q    <= PWDATA;
            if (wr_pol)  pol_q     <= PWDATA;
            if (wr_deb)  deb_cfg_q <= PWDATA[DEB_W-1:0];
        end
    end

    assign gpio_oe  = dir_q;
    assign gpio_out = out_q;

    // ------------------------------------------------------------------
    // Input synchronizer and edge history
    // ------------------------------------------------------------------

    // Two-flop synchronizer on the raw pads, plus a one-cycle copy of stable
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= gpio_in_raw;
            sync2_q <= sync1_q;
            prev_q  <= stable;
        end
    end

    // Per-pin debounce: stable only moves once sync has differed from it for
    // deb_cfg_q consecutive cycles; any return to stable restarts the count.
    for (genvar g = 0; g < 32; g++) begin : g_deb
        logic [DEB_W-1:0] cnt_q;
        logic [DEB_W-1:0] cnt_d;
        logic [DEB_W:0]   cnt_inc;
        logic             st_q;
        logic             st_d;

        // Widened increment so the threshold compare cannot wrap
        assign cnt_inc = {1'b0, cnt_q} + {{DEB_W{1'b0}}, 1'b1};

        // Next-state for counter and stable bit
        always_comb begin
            cnt_d = cnt_q;
            st_d  = st_q;
            if (sync2_q[g] == st_q) begin
                cnt_d = '0;
            end else if (cnt_inc >= {1'b0, deb_cfg_q}) begin
                st_d  = sync2_q[g];
                cnt_d = '0;
            end else begin
                cnt_d = cnt_inc[DEB_W-1:0];
            end
        end

        // Debounce state registers
        always_ff @(posedge PCLK or posedge PRESET) begin
            if (PRESET) begin
                cnt_q <= '0;
                st_q  <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                st_q  <= st_d;
            end
        end

        assign stable[g] = st_q;
    end

    // ------------------------------------------------------------------
    // Interrupts
    // ------------------------------------------------------------------

    // Event detection; polarity picks rising/high vs falling/low
    always_comb begin
        edge_ev  = (pol_q & stable & ~prev_q) | (~pol_q & ~stable & prev_q);
        level_ev = ~(stable ^ pol_q);
        int_ev   = mask_q & ((type_q & edge_ev) | (~type_q & level_ev));
        w1c_bits = wr_status ? PWDATA : 32'h0;
        // A same-cycle event wins over the clear
        status_d = (status_q & ~w1c_bits) | int_ev;
    end

    // Sticky interrupt status
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            status_q <= '0;
        end else begin
            status_q <= status_d;
        end
    end

    // Mask also gates the output so clearing a mask bit hides pending status
    assign gpio_irq = |(status_q & mask_q);

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------

    // Zero-extend the debounce threshold to the bus width
    always_comb begin
        deb_cfg_rd              = '0;
        deb_cfg_rd[DEB_W-1:0]   = deb_cfg_q;
    end

    // Combinational read data, zero when not reading or unmapped
    always_comb begin
        PRDATA = '0;
        if (rd_en) begin
            case (PADDR)
                ADDR_DIR:      PRDATA = dir_q;
                ADDR_OUT:      PRDATA = out_q;
                ADDR_IN:       PRDATA = stable;
                ADDR_MASK:     PRDATA = mask_q;
                ADDR_STATUS:   PRDATA = status_q;
                ADDR_TYPE:     PRDATA = type_q;
                ADDR_POLARITY: PRDATA = pol_q;
                ADDR_DEBOUNCE: PRDATA = deb_cfg_rd;
                default:       PRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_32_top.sv
// Self-checking bench for gpio_32_top: table-driven register vectors plus
// hand-written debounce, interrupt and reset sequences, scoreboarded reads.
module tb_gpio_32_top;

    logic        PCLK;
    logic        PRESET;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [31:0] gpio_in_raw;
    logic [31:0] gpio_out;
    logic [31:0] gpio_oe;
    logic        gpio_irq;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    string       nm_q[$];

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rexp;
        string       nm;
    } vec_t;

    vec_t vecs[9];

    gpio_32_top #(.DEB_W(16)) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR),
        .gpio_in_raw (gpio_in_raw),
        .gpio_out    (gpio_out),
        .gpio_oe     (gpio_oe),
        .gpio_irq    (gpio_irq)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Hard time limit so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        @(posedge PCLK);
        #1;
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
        @(posedge PCLK);
        #1;
        PENABLE = 1'b1;
        @(posedge PCLK);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    // Expected value is queued at issue, popped and compared when PRDATA is sampled
    task automatic rd_check(input logic [7:0] a, input logic [31:0] exp, input string nm);
        logic [31:0] got;
        logic [31:0] want;
        string       wnm;
        exp_q.push_back(exp);
        nm_q.push_back(nm);
        @(posedge PCLK);
        #1;
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
        @(posedge PCLK);
        #1;
        PENABLE = 1'b1;
        #1;
        got = PRDATA;
        @(posedge PCLK);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        want = exp_q.pop_front();
        wnm  = nm_q.pop_front();
        check(wnm, got, want);
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 8; i++) begin
            rd_check(8'(i * 4), 32'h0, $sformatf("%s_reg%0h", tag, i * 4));
        end
        check({tag, "_oe"},  gpio_oe, 32'h0);
        check({tag, "_out"}, gpio_out, 32'h0);
        check({tag, "_irq"}, 32'(gpio_irq), 32'h0);
    endtask

    initial begin
        vecs[0] = '{addr: 8'h00, wdata: 32'h0000_00FF, rexp: 32'h0000_00FF, nm: "dir"};
        vecs[1] = '{addr: 8'h04, wdata: 32'hA5A5_00FF, rexp: 32'hA5A5_00FF, nm: "out"};
        vecs[2] = '{addr: 8'h0C, wdata: 32'h0F0F_0F0F, rexp: 32'h0F0F_0F0F, nm: "mask"};
        vecs[3] = '{addr: 8'h14, wdata: 32'h1234_5678, rexp: 32'h1234_5678, nm: "type"};
        vecs[4] = '{addr: 8'h18, wdata: 32'hCAFE_BABE, rexp: 32'hCAFE_BABE, nm: "pol"};
        vecs[5] = '{addr: 8'h1C, wdata: 32'hFFFF_FFFF, rexp: 32'h0000_FFFF, nm: "deb_cfg"};
        vecs[6] = '{addr: 8'h08, wdata: 32'hFFFF_FFFF, rexp: 32'h0000_0000, nm: "in_ro"};
        vecs[7] = '{addr: 8'h20, wdata: 32'hFFFF_FFFF, rexp: 32'h0000_0000, nm: "unmapped20"};
        vecs[8] = '{addr: 8'h02, wdata: 32'hFFFF_FFFF, rexp: 32'h0000_0000, nm: "misaligned02"};

        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; gpio_in_raw = '0;
        wait_cycles(3);
        PRESET = 1'b0;

        // Reset state
        check("rst_prdata", PRDATA, 32'h0);
        check("rst_pready", 32'(PREADY), 32'h1);
        check("rst_pslverr", 32'(PSLVERR), 32'h0);
        check_all_zero("rst");

        // Register table
        for (int i = 0; i < 9; i++) begin
            apb_write(vecs[i].addr, vecs[i].wdata);
            if (vecs[i].addr == 8'h00) check("pad_oe", gpio_oe, vecs[i].rexp);
            if (vecs[i].addr == 8'h04) check("pad_out", gpio_out, vecs[i].rexp);
            rd_check(vecs[i].addr, vecs[i].rexp, vecs[i].nm);
        end
        rd_check(8'h00, 32'h0000_00FF, "dir_after_unmapped");
        check("pad_oe_hold", gpio_oe, 32'h0000_00FF);
        check("pad_out_hold", gpio_out, 32'hA5A5_00FF);

        // Clean slate
        PRESET = 1'b1;
        wait_cycles(2);
        PRESET = 1'b0;

        // Debounce threshold 4: short glitches must not pass
        apb_write(8'h1C, 32'd4);
        gpio_in_raw[0] = 1'b1; wait_cycles(1);
        gpio_in_raw[0] = 1'b0; wait_cycles(1);
        gpio_in_raw[0] = 1'b1; wait_cycles(1);
        gpio_in_raw[0] = 1'b0; wait_cycles(5);
        rd_check(8'h08, 32'h0, "deb_glitch");
        gpio_in_raw[0] = 1'b1;
        wait_cycles(2);
        rd_check(8'h08, 32'h0, "deb_early");
        wait_cycles(2);
        rd_check(8'h08, 32'h1, "deb_held");

        // Edge interrupt, rising
        apb_write(8'h1C, 32'd0);
        gpio_in_raw[0] = 1'b0;
        wait_cycles(6);
        apb_write(8'h0C, 32'h1);
        apb_write(8'h14, 32'h1);
        apb_write(8'h18, 32'h1);
        apb_write(8'h10, 32'hFFFF_FFFF);
        rd_check(8'h10, 32'h0, "edge_pre_status");
        check("edge_pre_irq", 32'(gpio_irq), 32'h0);
        gpio_in_raw[0] = 1'b1;
        wait_cycles(6);
        rd_check(8'h10, 32'h1, "edge_status");
        check("edge_irq", 32'(gpio_irq), 32'h1);
        apb_write(8'h10, 32'h1);
        rd_check(8'h10, 32'h0, "edge_w1c_status");
        check("edge_w1c_irq", 32'(gpio_irq), 32'h0);

        // Level interrupt, high; clear only sticks once the level drops
        apb_write(8'h14, 32'h0);
        wait_cycles(2);
        rd_check(8'h10, 32'h1, "level_status");
        check("level_irq", 32'(gpio_irq), 32'h1);
        apb_write(8'h10, 32'h1);
        rd_check(8'h10, 32'h1, "level_w1c_active");
        check("level_w1c_active_irq", 32'(gpio_irq), 32'h1);
        gpio_in_raw[0] = 1'b0;
        wait_cycles(6);
        apb_write(8'h10, 32'h1);
        rd_check(8'h10, 32'h0, "level_w1c_idle");
        check("level_w1c_idle_irq", 32'(gpio_irq), 32'h0);

        // Mask gating
        apb_write(8'h0C, 32'h0);
        apb_write(8'h14, 32'h1);
        gpio_in_raw[0] = 1'b1;
        wait_cycles(6);
        rd_check(8'h10, 32'h0, "masked_status");
        check("masked_irq", 32'(gpio_irq), 32'h0);
        apb_write(8'h18, 32'h0);
        apb_write(8'h0C, 32'h1);
        rd_check(8'h10, 32'h0, "pol_change_no_event");
        gpio_in_raw[0] = 1'b0;
        wait_cycles(6);
        rd_check(8'h10, 32'h1, "fall_status");
        check("fall_irq", 32'(gpio_irq), 32'h1);
        apb_write(8'h0C, 32'h0);
        check("mask_hide_irq", 32'(gpio_irq), 32'h0);
        rd_check(8'h10, 32'h1, "mask_hide_status_kept");

        // Unmapped read
        rd_check(8'h20, 32'h0, "unmapped_read");
        check("unmapped_pslverr", 32'(PSLVERR), 32'h0);

        // Reset during the access phase of a write
        apb_write(8'h00, 32'h0000_00F0);
        apb_write(8'h0C, 32'h1);
        check("pre_rst_oe", gpio_oe, 32'h0000_00F0);
        check("pre_rst_irq", 32'(gpio_irq), 32'h1);
        @(posedge PCLK);
        #1;
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = 8'h04; PWDATA = 32'h1234_5678; PENABLE = 1'b0;
        @(posedge PCLK);
        #1;
        PENABLE = 1'b1;
        #2;
        PRESET = 1'b1;
        #1;
        check("async_rst_oe", gpio_oe, 32'h0);
        check("async_rst_irq", 32'(gpio_irq), 32'h0);
        @(posedge PCLK);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        wait_cycles(1);
        PRESET = 1'b0;
        check_all_zero("midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpio_32_top.md
Name: gpio_32_top

Overview:
32-bit GPIO bank with an APB3 slave register interface: per-pin direction and output registers, a synchronized and debounced input path, and per-pin maskable edge/level interrupts combined into one IRQ line. It sits on the peripheral APB bus, between the pads and the interrupt controller.

Parameters:
DEB_W, 16, width of the debounce threshold field and of the per-pin debounce counters.

Ports:
PCLK  input  1  system/APB clock; all logic on the rising edge.
PRESET  input  1  reset; asynchronous and active-high; clears all state.
PSEL  input  1  APB select.
PENABLE  input  1  APB access phase.
PWRITE  input  1  1 = write, 0 = read.
PADDR  input  8  byte address.
PWDATA  input  32  write data.
PRDATA  output  32  read data.
PREADY  output  1  tied to 1 (no wait states).
PSLVERR  output  1  tied to 0.
gpio_in_raw  input  32  asynchronous pad inputs.
gpio_out  output  32  pad output values.
gpio_oe  output  32  pad output enables (1 = drive).
gpio_irq  output  1  combined interrupt, active-high.

Behaviour:
- Register map (word-aligned PADDR; any other address is unmapped):
  - 0x00 DIR, RW.
  - 0x04 OUT, RW.
  - 0x08 IN, RO, debounced value.
  - 0x0C INT_MASK, RW, 1 = enabled.
  - 0x10 INT_STATUS, RW1C.
  - 0x14 INT_TYPE, RW, 1 = edge, 0 = level.
  - 0x18 INT_POLARITY, RW, 1 = rising/high, 0 = falling/low.
  - 0x1C DEBOUNCE_CFG, RW, bits[DEB_W-1:0]; upper bits read 0.
- Reset values:
  - All registers, synchronizers, debounced state, edge history and counters = 0.
  - gpio_out = 0, gpio_oe = 0, gpio_irq = 0, PRDATA = 0, PREADY = 1, PSLVERR = 0.
- Writes:
  - Commit on the PCLK edge where PSEL & PENABLE & PWRITE.
  - Writes to IN and to unmapped addresses are ignored.
- Reads:
  - PRDATA is combinational: the selected register when PSEL & !PWRITE, otherwise 0.
  - Unmapped reads return 0.
- gpio_oe = DIR and gpio_out = OUT, directly from the registers; visible the cycle after the write.
- Input path, per bit and independent of DIR:
  - 2-flop synchronizer produces sync.
  - Debounce:
    - If sync == stable: counter = 0.
    - Else: counter increments; when counter+1 >= DEBOUNCE_CFG, stable <= sync and counter = 0.
    - DEBOUNCE_CFG = 0 or 1: stable follows sync with a 1-cycle delay.
  - Pulses shorter than DEBOUNCE_CFG cycles never reach stable.
  - IN reads stable.
- Interrupt events, per bit, from stable and prev (prev = stable delayed 1 cycle):
  - Edge: polarity 1 -> stable & !prev; polarity 0 -> !stable & prev.
  - Level: polarity 1 -> stable; polarity 0 -> !stable.
  - Event is qualified by INT_MASK; masked bits never set status.
- INT_STATUS:
  - Set by a qualified event; cleared by writing 1 to the bit.
  - Set has priority over a same-cycle W1C.
  - A level source therefore re-asserts every cycle while active, so clearing only sticks once the level is inactive.
- gpio_irq = OR of (INT_STATUS & INT_MASK), combinational.
  - Clearing a mask bit hides that bit's interrupt without clearing its status.
- Changing INT_TYPE/INT_POLARITY does not itself generate an event, except that a level condition that becomes true sets status on the next cycle.
- Asynchronous reset mid-transfer aborts the transfer and returns all state to reset values.

Test Plan:
- Write DIR = 0x000000FF, OUT = 0xA5A500FF -> gpio_oe = 0x000000FF, gpio_out = 0xA5A500FF; read back of both matches.
- DEBOUNCE_CFG = 4; bit0 toggles 1/0/1/0 one cycle each, then low 5 cycles -> IN[0] = 0. Then hold high 6 cycles -> IN[0] = 1.
- Edge interrupt:
  - Setup: MASK = 1, TYPE = 1, POL = 1, write STATUS = 0xFFFFFFFF; bit0 low, then rising and held.
  - -> STATUS[0] = 1, gpio_irq = 1.
  - Write STATUS = 1 -> STATUS[0] = 0, gpio_irq = 0.
- Level interrupt:
  - Setup: MASK = 1, TYPE = 0, POL = 1; bit0 high.
  - -> STATUS[0] = 1, irq = 1.
  - W1C while still high -> remains 1, irq = 1.
  - Drive low 6 cycles, then W1C -> STATUS[0] = 0, irq = 0.
- Mask gating: MASK = 0, rising edge on bit0 -> STATUS[0] = 0, irq = 0. Falling edge with POL = 0, MASK = 1 -> STATUS[0] = 1.
- Unmapped read 0x20 -> PRDATA = 0, PSLVERR = 0. Assert PRESET mid-operation -> all registers read 0, gpio_irq = 0.
